// File: rtl/wam_pkg.sv
// Shared definitions for the whack-a-mole game: mode encodings, point
// totals, the scorer state encoding and the light/key count.
package wam_pkg;

  // Number of lights on the board, and of keys on the keypad.
  localparam int NUM_LIGHTS = 9;

  // Width of a decoded key or light index.
  localparam int KEY_IDX_W = 4;

  // Flicks per game for the short and long game lengths.
  localparam int PTS_SHORT = 25;
  localparam int PTS_LONG  = 50;

  // Game modes selected from the top-level menu.
  typedef enum logic [1:0] {
    MODE_NORMAL     = 2'd0,
    MODE_TIMED      = 2'd1,
    MODE_DEATHMATCH = 2'd2,
    MODE_CONTINUITY = 2'd3
  } game_mode_e;

  // Scorer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ARMED = 2'd2,
    ST_DONE  = 2'd3
  } scorer_state_e;

endpackage

// File: rtl/wam_scorer_onehot_decoder.sv
// Maps a light pattern to {valid, index}. Only a pattern with exactly one
// bit set is valid; zero and multi-hot patterns both read as "no light".
module onehot_decoder #(
  parameter int N     = 9,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     pattern,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    valid = (pattern != '0) && ((pattern & (pattern - N'(1))) == '0);
  end

  // Position of the set bit; only meaningful when valid is high.
  always_comb begin
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (pattern[i]) begin
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wam_scorer.sv
// Scoring stage of the whack-a-mole game. Watches the light pattern and the
// key strobes, judges every light flick as a hit or a miss, keeps the
// hit/miss/flick counters and raises game_over/win at the end of a game.
module wam_scorer #(
  parameter int NUM_LIGHTS = wam_pkg::NUM_LIGHTS,
  parameter int PTS_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_LIGHTS-1:0] lights,
  input  logic                  key_valid,
  input  logic [3:0]            key_idx,
  input  logic [PTS_W-1:0]      total_points,
  input  logic                  deathmatch,
  output logic [PTS_W-1:0]      hits,
  output logic [PTS_W-1:0]      misses,
  output logic [PTS_W-1:0]      flicks,
  output logic                  hit_pulse,
  output logic                  miss_pulse,
  output logic                  game_over,
  output logic                  win
);

  import wam_pkg::*;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [PTS_W-1:0] sat_inc(input logic [PTS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NUM_LIGHTS-1:0] lights_q;
  logic                  enable_q;

  logic                  cur_valid;
  logic [KEY_IDX_W-1:0]  cur_idx;
  logic                  prev_valid;
  logic [KEY_IDX_W-1:0]  prev_idx;

  logic                  lights_changed;
  logic                  flick_start;
  logic                  enable_rise;

  scorer_state_e         state;
  scorer_state_e         state_n;
  logic [KEY_IDX_W-1:0]  target_idx;
  logic [KEY_IDX_W-1:0]  target_idx_n;
  logic [PTS_W-1:0]      target_total;
  logic [PTS_W-1:0]      target_total_n;
  logic [PTS_W-1:0]      hits_n;
  logic [PTS_W-1:0]      misses_n;
  logic [PTS_W-1:0]      flicks_n;
  logic [PTS_W-1:0]      judged_count;
  logic                  hit_n;
  logic                  miss_n;
  logic                  game_over_n;
  logic                  win_n;
  logic                  judged;
  logic                  judged_hit;
  logic                  rearm;

  // Decode both the live pattern and last cycle's pattern so that multi-hot
  // values compare as "off" on either side.
  onehot_decoder #(
    .N     (NUM_LIGHTS),
    .IDX_W (KEY_IDX_W)
  ) u_cur_decoder (
    .pattern (lights),
    .valid   (cur_valid),
    .index   (cur_idx)
  );

  onehot_decoder #(
    .N     (NUM_LIGHTS),
    .IDX_W (KEY_IDX_W)
  ) u_prev_decoder (
    .pattern (lights_q),
    .valid   (prev_valid),
    .index   (prev_idx)
  );

  // A flick ends on any change of the decoded light and starts when the new
  // decoded light is an actual light.
  always_comb begin
    lights_changed = (cur_valid != prev_valid) ||
                     (cur_valid && (cur_idx != prev_idx));
    flick_start    = cur_valid && lights_changed;
    enable_rise    = enable && !enable_q;
  end

  // Next-state and judgement logic. A judgement is resolved first; a flick
  // that starts in the same cycle is armed only if the game keeps going.
  always_comb begin
    state_n        = state;
    target_idx_n   = target_idx;
    target_total_n = target_total;
    hits_n         = hits;
    misses_n       = misses;
    flicks_n       = flicks;
    hit_n          = 1'b0;
    miss_n         = 1'b0;
    game_over_n    = game_over;
    win_n          = win;
    judged         = 1'b0;
    judged_hit     = 1'b0;
    judged_count   = flicks;
    rearm          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable_rise) begin
          target_total_n = total_points;
          state_n        = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else if (flick_start) begin
          flicks_n     = sat_inc(flicks);
          target_idx_n = cur_idx;
          if (key_valid) begin
            // Key in the very first cycle of the light: judge it right away.
            judged       = 1'b1;
            judged_hit   = (key_idx == cur_idx);
            judged_count = sat_inc(flicks);
          end else begin
            state_n = ST_ARMED;
          end
        end
      end

      ST_ARMED: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else if (key_valid || lights_changed) begin
          judged       = 1'b1;
          judged_hit   = key_valid && (key_idx == target_idx);
          judged_count = flicks;
          rearm        = flick_start;
          state_n      = ST_WAIT;
        end
      end

      default: begin
      end
    endcase

    if (judged) begin
      if (judged_hit) begin
        hits_n = sat_inc(hits);
        hit_n  = 1'b1;
      end else begin
        misses_n = sat_inc(misses);
        miss_n   = 1'b1;
      end

      if ((judged_count == target_total) || (deathmatch && !judged_hit)) begin
        state_n     = ST_DONE;
        game_over_n = 1'b1;
        win_n       = deathmatch ? (misses_n == '0)
                                 : ({hits_n, 1'b0} >= {1'b0, target_total});
      end else if (rearm) begin
        flicks_n     = sat_inc(flicks);
        target_idx_n = cur_idx;
        state_n      = ST_ARMED;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      lights_q     <= '0;
      enable_q     <= 1'b0;
      target_idx   <= '0;
      target_total <= '0;
      hits         <= '0;
      misses       <= '0;
      flicks       <= '0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      game_over    <= 1'b0;
      win          <= 1'b0;
    end else begin
      state        <= state_n;
      lights_q     <= lights;
      enable_q     <= enable;
      target_idx   <= target_idx_n;
      target_total <= target_total_n;
      hits         <= hits_n;
      misses       <= misses_n;
      flicks       <= flicks_n;
      hit_pulse    <= hit_n;
      miss_pulse   <= miss_n;
      game_over    <= game_over_n;
      win          <= win_n;
    end
  end

endmodule

// File: doc/wam_scorer.md
# wam_scorer

Scoring and judging stage of the whack-a-mole game, directly downstream of `light_controller` and `keypad_controller`. It watches the 9-bit light pattern and decoded key strobes, and judges each light flick as a hit or a miss. It counts hits, misses and flicks, and raises `game_over`/`win` when the configured point total is reached or a deathmatch miss occurs. Its outputs drive the score display and the top-level game FSM.

## Interface
- `NUM_LIGHTS`, 9: number of lights/keys; sets the width of `lights` and the range of `key_idx`.
- `PTS_W`, 6: width of `total_points` and of every counter.
- `clk`  in  1  system clock (CLOCK_50).
- `reset`  in  1  asynchronous, active-low; clears all state and outputs.
- `enable`  in  1  high while the top FSM is in PLAY.
- `lights`  in  NUM_LIGHTS  light pattern from `light_controller`; one-hot or zero.
- `key_valid`  in  1  one-cycle strobe; a key was pressed (already debounced).
- `key_idx`  in  4  index of the pressed key, 0..NUM_LIGHTS-1; qualified by `key_valid`.
- `total_points`  in  PTS_W  flicks per game (25 or 50).
- `deathmatch`  in  1  the first miss ends the game.
- `hits`, `misses`, `flicks`  out  PTS_W each  running counters.
- `hit_pulse`, `miss_pulse`  out  1  one-cycle judgement strobes.
- `game_over`  out  1  level; held until reset.
- `win`  out  1  valid while `game_over` is high.

## Operation
- Decided: one clock; reset is asynchronous and active-low (`clk`, `reset`).
- Reset value of every output is 0; the FSM resets to IDLE.
- `lights` is registered into `lights_q` and decoded to a target index.
- Any `lights` value with more than one bit set is treated as all-off.
- A flick starts in any cycle where decoded `lights` is non-zero and differs from `lights_q`.
- A flick ends when decoded `lights` differs from `lights_q`, whether it changes to 0 or to another light.
- States:
  - **IDLE**: counters held. On `enable` rising, latch `total_points` into `target_total` and go to WAIT.
  - **WAIT**: no light is armed. On flick start, latch the target index, increment `flicks` and go to ARMED. A `key_valid` here is ignored, with no penalty.
  - **ARMED**:
    - `key_valid` with `key_idx` equal to the target: hit. Increment `hits`, pulse `hit_pulse`, go to WAIT.
    - `key_valid` with a wrong index: miss. Increment `misses`, pulse `miss_pulse`, go to WAIT.
    - Flick end with no key: miss.
  - **DONE**: `game_over` held high. All inputs ignored until reset.
- Game end:
  - After any judgement, if `flicks == target_total`, go to DONE.
  - In deathmatch, any miss goes to DONE.
- `win`:
  - Deathmatch: `win = (misses == 0)`.
  - Otherwise: `win = (2*hits >= target_total)`, computed at PTS_W+1 bits.
- Simultaneous events:
  - A key in the same cycle as a flick end is judged against the old target, so a correct key is a hit.
  - If a new flick starts in that same cycle, it is armed on the same edge and `flicks` increments.
- Counters saturate at 2^PTS_W-1. They never wrap.
- `enable` low in WAIT or ARMED returns the FSM to IDLE. An armed flick is discarded without judgement, and counters are held.
- `reset` mid-game clears everything immediately, with no waiting for a clock edge.

## Timing
- `hit_pulse`/`miss_pulse` and the counter update are registered: they appear 1 cycle after the `key_valid` or flick-end edge.
- `game_over` rises in the same cycle as the final judgement strobe. `win` is valid in that cycle.
- Flick-start detection uses `lights_q`, so `flicks` updates 1 cycle after `lights` changes.
- Keys pressed within the first cycle of a light are still judged: the flick is armed on the same edge that samples the key.
- Throughput: one judgement per cycle maximum.

## Structure
- Shared package `wam_pkg`: game-mode encodings (NORMAL, TIMED, DEATHMATCH, CONTINUITY), the point constants 25 and 50, the scorer state enum, and `NUM_LIGHTS`.
- One natural sub-module, `onehot_decoder`: maps `lights` to {valid, index}, with multi-hot treated as invalid.
- Counters and FSM stay inline.

## Test plan
- Normal game, total 25: 25 flicks, each followed within the window by a matching `key_idx` -> hits=25, misses=0, `game_over`=1, `win`=1.
- Wrong key: light 4 on, key_idx=2 -> `miss_pulse` once, misses=1, and a later key_idx=4 during the same light is ignored.
- Timeout: light 7 on then off with no key -> misses=1. Light 7 directly followed by light 3 -> misses=1, flicks=2.
- Deathmatch with 10 hits then 1 timeout -> `game_over`=1, `win`=0, flicks=11.
- Same-cycle event: correct `key_valid` in the cycle lights changes from 5 to 8 -> hits+1, flicks+1, and the FSM is ARMED on light 8.
- Reset: assert `reset` low mid-ARMED with hits=6 -> all outputs 0 asynchronously. After release, multi-hot `lights`=9'h03 produces no flick.
